// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between requester 0 (instruction fetch,
// read only) and requester 1 (data access). The winner gets a fixed-latency
// access of MEM_LAT cycles followed by a one-cycle Done pulse. Ties are
// broken round-robin against the last granted requester.
//
// Ports:
//   Clk    - clock, rising edge
//   Reset  - synchronous, active-high reset
//   Req0   - access request, requester 0
//   Req1   - access request, requester 1
//   Wr1    - requester 1 write qualifier, captured at grant
//   Sel    - shared-path mux select (0 = requester 0, 1 = requester 1)
//   Gnt0   - requester 0 owns the port
//   Gnt1   - requester 1 owns the port
//   Done0  - one-cycle completion pulse, requester 0
//   Done1  - one-cycle completion pulse, requester 1
//   MemEn  - memory enable
//   MemWr  - memory write enable
//   Busy   - arbiter not idle
//
// All outputs are registered. MEM_LAT must be 1..15 and 2**CNT_W > MEM_LAT.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Req0,
  input  logic Req1,
  input  logic Wr1,
  output logic Sel,
  output logic Gnt0,
  output logic Gnt1,
  output logic Done0,
  output logic Done1,
  output logic MemEn,
  output logic MemWr,
  output logic Busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;
  logic             r_sel;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_done0;
  logic             r_done1;
  logic             r_mem_en;
  logic             r_mem_wr;
  logic             r_busy;

  logic [1:0]       w_state_d;
  logic [CNT_W-1:0] w_cnt_d;
  logic             w_last_d;
  logic             w_sel_d;
  logic             w_gnt0_d;
  logic             w_gnt1_d;
  logic             w_done0_d;
  logic             w_done1_d;
  logic             w_mem_en_d;
  logic             w_mem_wr_d;
  logic             w_busy_d;

  logic             w_any_req;
  logic             w_winner;

  // On a tie the requester that was not granted last time wins.
  assign w_any_req = Req0 | Req1;
  assign w_winner  = (Req0 & Req1) ? ~r_last : Req1;

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_last_d   = r_last;
    w_sel_d    = r_sel;
    w_gnt0_d   = r_gnt0;
    w_gnt1_d   = r_gnt1;
    w_done0_d  = 1'b0;
    w_done1_d  = 1'b0;
    w_mem_en_d = r_mem_en;
    w_mem_wr_d = r_mem_wr;
    w_busy_d   = r_busy;

    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_d  = ACCESS;
          w_sel_d    = w_winner;
          w_gnt0_d   = ~w_winner;
          w_gnt1_d   = w_winner;
          w_mem_en_d = 1'b1;
          w_mem_wr_d = w_winner & Wr1;
          w_cnt_d    = CNT_LOAD;
          w_last_d   = w_winner;
          w_busy_d   = 1'b1;
        end
      end
      ACCESS: begin
        if (r_cnt == '0) begin
          w_state_d  = RESP;
          w_gnt0_d   = 1'b0;
          w_gnt1_d   = 1'b0;
          w_mem_en_d = 1'b0;
          w_mem_wr_d = 1'b0;
          // Sel still names the owner of the finishing access.
          w_done0_d  = ~r_sel;
          w_done1_d  = r_sel;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      RESP: begin
        w_state_d = IDLE;
        w_busy_d  = 1'b0;
      end
      default: begin
        w_state_d  = IDLE;
        w_gnt0_d   = 1'b0;
        w_gnt1_d   = 1'b0;
        w_mem_en_d = 1'b0;
        w_mem_wr_d = 1'b0;
        w_busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_last   <= 1'b1;
      r_sel    <= 1'b0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_mem_en <= 1'b0;
      r_mem_wr <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_last   <= w_last_d;
      r_sel    <= w_sel_d;
      r_gnt0   <= w_gnt0_d;
      r_gnt1   <= w_gnt1_d;
      r_done0  <= w_done0_d;
      r_done1  <= w_done1_d;
      r_mem_en <= w_mem_en_d;
      r_mem_wr <= w_mem_wr_d;
      r_busy   <= w_busy_d;
    end
  end

  assign Sel   = r_sel;
  assign Gnt0  = r_gnt0;
  assign Gnt1  = r_gnt1;
  assign Done0 = r_done0;
  assign Done1 = r_done1;
  assign MemEn = r_mem_en;
  assign MemWr = r_mem_wr;
  assign Busy  = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Two instances (MEM_LAT=2 and
// MEM_LAT=1) share the same stimulus. A transaction-timeline model predicts
// every output each cycle: a granted access started in cycle t owns the port
// in t+1..t+L, signals Done in t+L+1 and frees the arbiter at t+L+2.
module tb_mem_port_arbiter;

  logic Clk = 1'b0;
  logic Reset, Req0, Req1, Wr1;
  logic [7:0] w_obs [2];

  logic sel_a, g0_a, g1_a, d0_a, d1_a, en_a, wr_a, bz_a;
  logic sel_b, g0_b, g1_b, d0_b, d1_b, en_b, wr_b, bz_b;

  always #5 Clk = ~Clk;

  mem_port_arbiter #(.MEM_LAT(2), .CNT_W(4)) u_dut_l2 (
    .Clk(Clk), .Reset(Reset), .Req0(Req0), .Req1(Req1), .Wr1(Wr1),
    .Sel(sel_a), .Gnt0(g0_a), .Gnt1(g1_a), .Done0(d0_a), .Done1(d1_a),
    .MemEn(en_a), .MemWr(wr_a), .Busy(bz_a)
  );

  mem_port_arbiter #(.MEM_LAT(1), .CNT_W(4)) u_dut_l1 (
    .Clk(Clk), .Reset(Reset), .Req0(Req0), .Req1(Req1), .Wr1(Wr1),
    .Sel(sel_b), .Gnt0(g0_b), .Gnt1(g1_b), .Done0(d0_b), .Done1(d1_b),
    .MemEn(en_b), .MemWr(wr_b), .Busy(bz_b)
  );

  assign w_obs[0] = {sel_a, g0_a, g1_a, d0_a, d1_a, en_a, wr_a, bz_a};
  assign w_obs[1] = {sel_b, g0_b, g1_b, d0_b, d1_b, en_b, wr_b, bz_b};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state per instance.
  int lat    [2] = '{2, 1};
  bit active [2];
  int start  [2];
  bit who    [2];
  bit wr     [2];
  bit last   [2];
  bit sel    [2];

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got={sel,g0,g1,d0,d1,en,wr,busy}=%b want=%b",
               tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [7:0] expected(input int k);
    logic [7:0] e;
    int d;
    e    = '0;
    e[7] = sel[k];
    if (active[k]) begin
      d = cyc - start[k];
      if (d >= 1 && d <= lat[k]) begin
        e[6] = ~who[k];
        e[5] = who[k];
        e[2] = 1'b1;
        e[1] = wr[k];
        e[0] = 1'b1;
      end else if (d == lat[k] + 1) begin
        e[4] = ~who[k];
        e[3] = who[k];
        e[0] = 1'b1;
      end
    end
    return e;
  endfunction

  // Apply inputs for the current cycle, advance the model, then check the
  // outputs produced by the following edge.
  task automatic step(input bit rst, input bit r0, input bit r1, input bit w1);
    Reset = rst;
    Req0  = r0;
    Req1  = r1;
    Wr1   = w1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        active[k] = 1'b0;
        sel[k]    = 1'b0;
        last[k]   = 1'b1;
      end else if (!active[k] && (r0 || r1)) begin
        who[k]    = (r0 && r1) ? !last[k] : r1;
        wr[k]     = who[k] && w1;
        start[k]  = cyc;
        active[k] = 1'b1;
        last[k]   = who[k];
        sel[k]    = who[k];
      end
    end
    @(posedge Clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (active[k] && (cyc - start[k] >= lat[k] + 2)) active[k] = 1'b0;
    end
    check_val("lat2", w_obs[0], expected(0));
    check_val("lat1", w_obs[1], expected(1));
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      active[k] = 1'b0;
      sel[k]    = 1'b0;
      last[k]   = 1'b1;
    end
    Reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0; Wr1 = 1'b0;

    // Reset, then a lone requester-0 read.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

    // Requester-1 write with Wr1 dropping after grant.
    step(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

    // Both requesting continuously from reset: alternating grants.
    step(1, 1, 1, 1);
    for (int i = 0; i < 20; i++) step(0, 1, 1, 1);

    // Reset during the second access cycle of a requester-1 write.
    step(1, 0, 0, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    step(1, 0, 1, 1);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0);

    // Requester 0 drops its request after one access cycle.
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(63) == 0),
           ($urandom_range(9) < 6),
           ($urandom_range(9) < 6),
           ($urandom_range(1) == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
